// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage ahead of the controller/datapath. Owns the PC,
//                requests words from instruction memory over req/ack, holds
//                the returned word until execute consumes it, then picks the
//                next PC (branch target or PC+4).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic             instr_valid,
  input  logic             exec_ready,
  input  logic             PCSrc,
  input  logic [31:0]      Result,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus8,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [31:0] c_step4 = 32'd4;
  localparam logic [31:0] c_step8 = 32'd8;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_req;
  logic             r_valid;
  logic             r_misalign;
  logic [CNT_W-1:0] r_retired;

  logic [31:0]      w_next_pc;
  logic             w_target_misaligned;

  // Next-PC selection: aligned branch target or sequential PC+4 (wraps mod 2^32)
  always_comb begin
    w_next_pc           = r_pc + c_step4;
    w_target_misaligned = 1'b0;
    if (PCSrc) begin
      w_next_pc           = {Result[31:2], 2'b00};
      w_target_misaligned = |Result[1:0];
    end
  end

  // Fetch FSM with registered request/valid flags and PC/counter updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        // Wait out any ack left over from a transaction cut short by reset
        S_IDLE: begin
          if (!imem_ack) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        // Request held stable at the current PC until memory acknowledges
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_ISSUE;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        // Word held for execute; PCSrc/Result only matter on the consume cycle
        S_ISSUE: begin
          if (exec_ready) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + CNT_W'(1);
            if (w_target_misaligned) begin
              r_misalign <= 1'b1;
            end
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign Instr       = r_instr;
  assign instr_valid = r_valid;
  assign PC          = r_pc;
  assign PCPlus8     = r_pc + c_step8;
  assign misalign    = r_misalign;
  assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed, table-driven bench for instr_fetch plus hand
//                sequences for stall, ack latency, wrap and reset corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      Instr;
  logic             instr_valid;
  logic             exec_ready;
  logic             PCSrc;
  logic [31:0]      Result;
  logic [31:0]      PC;
  logic [31:0]      PCPlus8;
  logic             misalign;
  logic [CNT_W-1:0] retired;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .PCSrc       (PCSrc),
    .Result      (Result),
    .PC          (PC),
    .PCPlus8     (PCPlus8),
    .misalign    (misalign),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        src;
    logic [31:0] res;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        mis;
    logic [3:0]  ret;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] instr, input logic [31:0] pc8,
                           input logic mis, input logic [3:0] ret);
    check({tag, ".req"},      32'(imem_req),    32'(req));
    check({tag, ".addr"},     imem_addr,        addr);
    check({tag, ".pc"},       PC,               addr);
    check({tag, ".valid"},    32'(instr_valid), 32'(vld));
    check({tag, ".instr"},    Instr,            instr);
    check({tag, ".pcplus8"},  PCPlus8,          pc8);
    check({tag, ".misalign"}, 32'(misalign),    32'(mis));
    check({tag, ".retired"},  32'(retired),     32'(ret));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later
  task automatic step(input logic ack, input logic [31:0] rdata, input logic rdy,
                      input logic src, input logic [31:0] res);
    imem_ack   = ack;
    imem_rdata = rdata;
    exec_ready = rdy;
    PCSrc      = src;
    Result     = res;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [3:0]  exp_ret;
  logic        exp_mis;

  initial begin
    //            ack rdata         rdy src res            req addr          vld instr         pc8           mis ret
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0000_0008, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 32'hE3A0_1005,1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0000, 1'b1, 32'hE3A0_1005,32'h0000_0008, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b0, 32'hE3A0_1005,32'h0000_000C, 1'b0, 4'd1};
    vecs[3]  = '{1'b1, 32'h1111_1111,1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0004, 1'b1, 32'h1111_1111,32'h0000_000C, 1'b0, 4'd1};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h3,   1'b1, 32'h0000_0008, 1'b0, 32'h1111_1111,32'h0000_0010, 1'b0, 4'd2};
    vecs[5]  = '{1'b1, 32'h2222_2222,1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0008, 1'b1, 32'h2222_2222,32'h0000_0010, 1'b0, 4'd2};
    vecs[6]  = '{1'b1, 32'hDEAD_BEEF,1'b0, 1'b1, 32'h200, 1'b0, 32'h0000_0008, 1'b1, 32'h2222_2222,32'h0000_0010, 1'b0, 4'd2};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,  1'b1, 32'h0000_0010, 1'b0, 32'h2222_2222,32'h0000_0018, 1'b0, 4'd3};
    vecs[8]  = '{1'b1, 32'h3333_3333,1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 1'b1, 32'h3333_3333,32'h0000_0018, 1'b0, 4'd3};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h102, 1'b1, 32'h0000_0100, 1'b0, 32'h3333_3333,32'h0000_0108, 1'b1, 4'd4};
    vecs[10] = '{1'b1, 32'h4444_4444,1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0100, 1'b1, 32'h4444_4444,32'h0000_0108, 1'b1, 4'd4};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0104, 1'b0, 32'h4444_4444,32'h0000_010C, 1'b1, 4'd5};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h500, 1'b1, 32'h0000_0104, 1'b0, 32'h4444_4444,32'h0000_010C, 1'b1, 4'd5};

    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    exec_ready = 1'b0;
    PCSrc      = 1'b0;
    Result     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0, 4'd0);
    reset = 1'b0;
    check("idle_req", 32'(imem_req), 32'h0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].src, vecs[i].res);
      check_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
                vecs[i].instr, vecs[i].pc8, vecs[i].mis, vecs[i].ret);
    end

    exp_pc    = 32'h0000_0104;
    exp_instr = 32'h4444_4444;
    exp_ret   = 4'd5;
    exp_mis   = 1'b1;

    // Ack latency: request and address stay put while memory is slow
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 32'h0);
      check_out($sformatf("lat%0d", k), 1'b1, exp_pc, 1'b0, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);
    end
    step(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    exp_instr = 32'h5555_5555;
    check_out("lat_ack", 1'b0, exp_pc, 1'b1, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);

    // Stall: PCSrc toggles while not ready, nothing may move
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'h0, 1'b0, k[0], 32'h800);
      check_out($sformatf("stall%0d", k), 1'b0, exp_pc, 1'b1, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h800);
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 4'd1;
    check_out("stall_rel", 1'b1, exp_pc, 1'b0, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);
    check("stall_rel_addr", imem_addr, 32'h0000_0108);

    // Branch to the last word, then sequential wrap to zero
    step(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    exp_instr = 32'h6666_6666;
    exp_ret   = exp_ret + 4'd1;
    check_out("top", 1'b1, 32'hFFFF_FFFC, 1'b0, exp_instr, 32'h0000_0004, exp_mis, exp_ret);
    step(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    exp_instr = 32'h7777_7777;
    exp_ret   = exp_ret + 4'd1;
    exp_pc    = 32'h0;
    check_out("wrap", 1'b1, 32'h0000_0000, 1'b0, exp_instr, 32'h0000_0008, exp_mis, exp_ret);

    // Retired counter rolls over from 15 to 0 (4-bit instance)
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 32'h0);
      exp_instr = 32'hA000_0000 + 32'(k);
      check_out($sformatf("run%0d.issue", k), 1'b0, exp_pc, 1'b1, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      exp_pc  = exp_pc + 32'd4;
      exp_ret = exp_ret + 4'd1;
      check_out($sformatf("run%0d.next", k), 1'b1, exp_pc, 1'b0, exp_instr, exp_pc + 32'd8, exp_mis, exp_ret);
    end
    check("retired_wrap", 32'(retired), 32'h0);

    // Reset in FETCH with ack held high across release
    imem_ack   = 1'b1;
    imem_rdata = 32'h9999_9999;
    #1;
    reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
      check_out($sformatf("drain%0d", k), 1'b0, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0, 4'd0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("refetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0, 4'd0);
    step(1'b1, 32'hABCD_0123, 1'b0, 1'b0, 32'h0);
    check_out("refetch_ack", 1'b0, 32'h0, 1'b1, 32'hABCD_0123, 32'h8, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
